lsq_ret_buffer: RTL

- In-order retire staging buffer directly upstream of the LSQ retire-decide stage.
- Allocates one entry per memory retire bundle (bundle II), collects per-slot completion status from the memory pipes, and presents the oldest fully-completed bundle on the dataB_* interface.
- Frees the head entry when the decide stage accepts it (dataB_enOut). Flushes all entries on exception.

---
 rtl/lsq_ret_buffer_if.sv | 75 +++++++
 rtl/lsq_ret_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lsq_ret_buffer_if.sv
// Bundle interface for the LSQ retire staging buffer: allocation, two
// completion write ports and the head (dataB) presentation to retire-decide.
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

interface lsq_ret_buffer_if #(
    parameter int unsigned PTR_W = 3
);
    logic                       alloc_en;
    logic [5:0]                 alloc_II;
    logic                       alloc_thread;
    logic [5:0]                 alloc_mask;
    logic [23:0]                alloc_slotII;
    logic [`LSQSHARE_WIDTH-1:0] alloc_shr;
    logic                       alloc_ready;
    logic [PTR_W-1:0]           alloc_ptr;

    logic                       wr0_en;
    logic [PTR_W-1:0]           wr0_ptr;
    logic [2:0]                 wr0_slot;
    logic                       wr0_excpt;
    logic                       wr0_ldconfl;
    logic                       wr0_waitconfl;
    logic [3:0]                 wr0_exbits;
    logic                       wr1_en;
    logic [PTR_W-1:0]           wr1_ptr;
    logic [2:0]                 wr1_slot;
    logic                       wr1_excpt;
    logic                       wr1_ldconfl;
    logic                       wr1_waitconfl;
    logic [3:0]                 wr1_exbits;

    logic                       dataB_ready;
    logic [5:0]                 dataB_II;
    logic                       dataB_thread;
    logic [5:0]                 dataB_ret_mask;
    logic [5:0]                 dataB_excpt;
    logic [5:0]                 dataB_ld_confl;
    logic [5:0]                 dataB_wait_confl;
    logic [23:0]                dataB_exbits;
    logic [3:0]                 dataB_II0;
    logic [3:0]                 dataB_II1;
    logic [3:0]                 dataB_II2;
    logic [3:0]                 dataB_II3;
    logic [3:0]                 dataB_II4;
    logic [3:0]                 dataB_II5;
    logic [`LSQSHARE_WIDTH-1:0] dataB_data_shr;
    logic                       dataB_enOut;
    logic                       except;

    modport slave (
        input  alloc_en, alloc_II, alloc_thread, alloc_mask, alloc_slotII, alloc_shr,
        output alloc_ready, alloc_ptr,
        input  wr0_en, wr0_ptr, wr0_slot, wr0_excpt, wr0_ldconfl, wr0_waitconfl, wr0_exbits,
        input  wr1_en, wr1_ptr, wr1_slot, wr1_excpt, wr1_ldconfl, wr1_waitconfl, wr1_exbits,
        output dataB_ready, dataB_II, dataB_thread, dataB_ret_mask, dataB_excpt,
        output dataB_ld_confl, dataB_wait_confl, dataB_exbits,
        output dataB_II0, dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5,
        output dataB_data_shr,
        input  dataB_enOut, except
    );

    modport master (
        output alloc_en, alloc_II, alloc_thread, alloc_mask, alloc_slotII, alloc_shr,
        input  alloc_ready, alloc_ptr,
        output wr0_en, wr0_ptr, wr0_slot, wr0_excpt, wr0_ldconfl, wr0_waitconfl, wr0_exbits,
        output wr1_en, wr1_ptr, wr1_slot, wr1_excpt, wr1_ldconfl, wr1_waitconfl, wr1_exbits,
        input  dataB_ready, dataB_II, dataB_thread, dataB_ret_mask, dataB_excpt,
        input  dataB_ld_confl, dataB_wait_confl, dataB_exbits,
        input  dataB_II0, dataB_II1, dataB_II2, dataB_II3, dataB_II4, dataB_II5,
        input  dataB_data_shr,
        output dataB_enOut, except
    );
endinterface

// File: rtl/lsq_ret_buffer.sv
// In-order retire staging buffer: one entry per memory bundle, collects slot
// completions and presents the oldest fully-completed bundle to retire-decide.
`ifndef LSQSHARE_WIDTH
`define LSQSHARE_WIDTH 16
`endif

module lsq_ret_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input logic             clk,
    input logic             rst,
    lsq_ret_buffer_if.slave bus
);
    localparam int unsigned ShrW = `LSQSHARE_WIDTH;
    localparam logic [PTR_W:0] Full = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [5:0]       ii_q     [DEPTH];
    logic [5:0]       ii_d     [DEPTH];
    logic             thr_q    [DEPTH];
    logic             thr_d    [DEPTH];
    logic [5:0]       mask_q   [DEPTH];
    logic [5:0]       mask_d   [DEPTH];
    logic [23:0]      slotii_q [DEPTH];
    logic [23:0]      slotii_d [DEPTH];
    logic [ShrW-1:0]  shr_q    [DEPTH];
    logic [ShrW-1:0]  shr_d    [DEPTH];
    logic [5:0]       done_q   [DEPTH];
    logic [5:0]       done_d   [DEPTH];
    logic [5:0]       exc_q    [DEPTH];
    logic [5:0]       exc_d    [DEPTH];
    logic [5:0]       ldc_q    [DEPTH];
    logic [5:0]       ldc_d    [DEPTH];
    logic [5:0]       wtc_q    [DEPTH];
    logic [5:0]       wtc_d    [DEPTH];
    logic [23:0]      exb_q    [DEPTH];
    logic [23:0]      exb_d    [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             head_ready;
    logic             do_alloc, do_pop;
    logic [1:0]       wr_en;
    logic [PTR_W-1:0] wr_ptr  [2];
    logic [2:0]       wr_slot [2];
    logic [1:0]       wr_exc, wr_ldc, wr_wtc;
    logic [3:0]       wr_exb  [2];

    assign wr_en      = {bus.wr1_en, bus.wr0_en};
    assign wr_ptr[0]  = bus.wr0_ptr;
    assign wr_ptr[1]  = bus.wr1_ptr;
    assign wr_slot[0] = bus.wr0_slot;
    assign wr_slot[1] = bus.wr1_slot;
    assign wr_exc     = {bus.wr1_excpt, bus.wr0_excpt};
    assign wr_ldc     = {bus.wr1_ldconfl, bus.wr0_ldconfl};
    assign wr_wtc     = {bus.wr1_waitconfl, bus.wr0_waitconfl};
    assign wr_exb[0]  = bus.wr0_exbits;
    assign wr_exb[1]  = bus.wr1_exbits;

    assign head_ready      = valid_q[head_q] &&
                             ((done_q[head_q] & mask_q[head_q]) == mask_q[head_q]);
    // Space is judged on the registered count only; a same-cycle pop does not help.
    assign bus.alloc_ready = (count_q != Full);
    assign bus.alloc_ptr   = tail_q;
    assign do_alloc        = bus.alloc_en && bus.alloc_ready;
    assign do_pop          = bus.dataB_enOut && head_ready;

    always_comb begin
        valid_d  = valid_q;
        ii_d     = ii_q;
        thr_d    = thr_q;
        mask_d   = mask_q;
        slotii_d = slotii_q;
        shr_d    = shr_q;
        done_d   = done_q;
        exc_d    = exc_q;
        ldc_d    = ldc_q;
        wtc_d    = wtc_q;
        exb_d    = exb_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        // Port 1 is applied after port 0 so it wins on a same-slot collision.
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p] && valid_q[wr_ptr[p]] && !(do_pop && wr_ptr[p] == head_q)) begin
                for (int s = 0; s < 6; s++) begin
                    if (wr_slot[p] == 3'(s) && mask_q[wr_ptr[p]][s]) begin
                        done_d[wr_ptr[p]][s]       = 1'b1;
                        exc_d[wr_ptr[p]][s]        = wr_exc[p];
                        ldc_d[wr_ptr[p]][s]        = wr_ldc[p];
                        wtc_d[wr_ptr[p]][s]        = wr_wtc[p];
                        exb_d[wr_ptr[p]][4*s +: 4] = wr_exb[p];
                    end
                end
            end
        end

        if (do_alloc) begin
            valid_d[tail_q]  = 1'b1;
            ii_d[tail_q]     = bus.alloc_II;
            thr_d[tail_q]    = bus.alloc_thread;
            mask_d[tail_q]   = bus.alloc_mask;
            slotii_d[tail_q] = bus.alloc_slotII;
            shr_d[tail_q]    = bus.alloc_shr;
            done_d[tail_q]   = '0;
            exc_d[tail_q]    = '0;
            ldc_d[tail_q]    = '0;
            wtc_d[tail_q]    = '0;
            exb_d[tail_q]    = '0;
            tail_d           = tail_q + PTR_W'(1);
        end

        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        unique case ({do_alloc, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (bus.except) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            ii_q     <= '{default: '0};
            thr_q    <= '{default: '0};
            mask_q   <= '{default: '0};
            slotii_q <= '{default: '0};
            shr_q    <= '{default: '0};
            done_q   <= '{default: '0};
            exc_q    <= '{default: '0};
            ldc_q    <= '{default: '0};
            wtc_q    <= '{default: '0};
            exb_q    <= '{default: '0};
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            ii_q     <= ii_d;
            thr_q    <= thr_d;
            mask_q   <= mask_d;
            slotii_q <= slotii_d;
            shr_q    <= shr_d;
            done_q   <= done_d;
            exc_q    <= exc_d;
            ldc_q    <= ldc_d;
            wtc_q    <= wtc_d;
            exb_q    <= exb_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Everything on dataB reads as zero while the head slot is empty.
    always_comb begin
        bus.dataB_ready      = 1'b0;
        bus.dataB_II         = '0;
        bus.dataB_thread     = 1'b0;
        bus.dataB_ret_mask   = '0;
        bus.dataB_excpt      = '0;
        bus.dataB_ld_confl   = '0;
        bus.dataB_wait_confl = '0;
        bus.dataB_exbits     = '0;
        bus.dataB_II0        = '0;
        bus.dataB_II1        = '0;
        bus.dataB_II2        = '0;
        bus.dataB_II3        = '0;
        bus.dataB_II4        = '0;
        bus.dataB_II5        = '0;
        bus.dataB_data_shr   = '0;
        if (valid_q[head_q]) begin
            bus.dataB_ready      = head_ready;
            bus.dataB_II         = ii_q[head_q];
            bus.dataB_thread     = thr_q[head_q];
            bus.dataB_ret_mask   = mask_q[head_q];
            bus.dataB_excpt      = exc_q[head_q];
            bus.dataB_ld_confl   = ldc_q[head_q];
            bus.dataB_wait_confl = wtc_q[head_q];
            bus.dataB_exbits     = exb_q[head_q];
            bus.dataB_II0        = slotii_q[head_q][3:0];
            bus.dataB_II1        = slotii_q[head_q][7:4];
            bus.dataB_II2        = slotii_q[head_q][11:8];
            bus.dataB_II3        = slotii_q[head_q][15:12];
            bus.dataB_II4        = slotii_q[head_q][19:16];
            bus.dataB_II5        = slotii_q[head_q][23:20];
            bus.dataB_data_shr   = shr_q[head_q];
        end
    end
endmodule
